booth_seq_mult: RTL and testbench

- Sequential radix-4 signed Booth multiplier. It sits directly downstream of booth_pp and consumes its output.
- It recodes multiplier x into overlapping Booth triplets, LSB-first, one triplet per cycle. Each triplet drives an internal booth_pp instance (PIPE=0) with multiplicand y.
- It accumulates the returned pp/cpl pair, shifted by 2 bits per step, into a 2W-bit product.
- Valid/ready handshakes on input and output; one multiply in flight at a time.

---
 rtl/booth_seq_mult.sv | 135 +++++++++++++
 tb/tb_booth_seq_mult.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 signed Booth multiplier: one recoded triplet of x per cycle, LSB-first,
// accumulated into a 2W-bit product, with valid/ready handshakes on both sides.

// booth_pp: one radix-4 Booth partial product of y for a triplet (combinational, PIPE=0 form).
// Negative digits return the inverted positive multiple with cpl=1, so sext(pp)+cpl == digit*y.
module booth_pp #(
  parameter int W = 16
) (
  input  logic [2:0]   trip,
  input  logic [W-1:0] y,
  output logic [W:0]   pp,
  output logic         cpl
);
  always_comb begin
    pp  = '0;
    cpl = 1'b0;
    case (trip)
      3'b001, 3'b010: pp = {y[W-1], y};
      3'b011:         pp = {y, 1'b0};
      3'b100: begin
        pp  = ~{y, 1'b0};
        cpl = 1'b1;
      end
      3'b101, 3'b110: begin
        pp  = ~{y[W-1], y};
        cpl = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | one Booth step per cycle, W/2 steps
// DONE  | product presented, waiting for out_ready
module booth_seq_mult #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);
  localparam int N  = W / 2;
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    xr, yr;
  logic [SW-1:0]   step;
  logic [2*W+1:0]  acc, acc_next, pp_ext, contrib;
  logic [W:0]      xe;
  logic [2:0]      trip;
  logic [W:0]      pp;
  logic            cpl;
  logic            last_step;

  // xr[-1] = 0 is supplied by the appended zero, so triplet i is xe[2i+2:2i]
  assign xe        = {xr, 1'b0};
  assign trip      = xe[{step, 1'b0} +: 3];
  assign last_step = (step == SW'(N - 1));

  booth_pp #(.W(W)) u_pp (
    .trip (trip),
    .y    (yr),
    .pp   (pp),
    .cpl  (cpl)
  );

  assign pp_ext   = {{(W+1){pp[W]}}, pp} + {{(2*W+1){1'b0}}, cpl};
  assign contrib  = pp_ext << {step, 1'b0};
  assign acc_next = acc + contrib;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr        <= '0;
      yr        <= '0;
      acc       <= '0;
      step      <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr   <= x;
            yr   <= y;
            acc  <= '0;
            step <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (last_step) begin
            step      <= '0;
            product   <= acc_next[2*W-1:0];
            out_valid <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult (W=16): hand-computed products, latency, backpressure,
// back-to-back throughput and mid-run reset.
module tb_booth_seq_mult;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  booth_seq_mult #(.W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full multiply with out_ready held high
  task automatic run_mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
    int lat;
    bit ir_seen;
    check({tag, " ready"}, in_ready, 1'b1);
    x = a;
    y = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = ~a;
    y = ~b;
    lat = 0;
    ir_seen = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready) ir_seen = 1;
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 8);
    check({tag, " in_ready low"}, {ir_seen, in_ready}, 2'b00);
    check({tag, " product"}, product, exp);
    tick();
    check({tag, " drained"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  logic [15:0] bx [4] = '{16'h0003, 16'hFFFF, 16'h8000, 16'h0064};
  logic [15:0] by [4] = '{16'h0005, 16'hFFFF, 16'h8000, 16'h0064};
  logic [31:0] bp [4] = '{32'h0000000F, 32'h00000001, 32'h40000000, 32'h00002710};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc [4];
    int idx, oidx, cyc;
    bit acc_now, pv_bad;
    logic [31:0] held;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset outputs", {out_valid, product, in_ready, busy}, {1'b0, 32'h0, 1'b1, 1'b0});

    run_mult("3x5",        16'h0003, 16'h0005, 32'h0000000F);
    run_mult("m1xm1",      16'hFFFF, 16'hFFFF, 32'h00000001);
    run_mult("minxmin",    16'h8000, 16'h8000, 32'h40000000);
    run_mult("minxmax",    16'h8000, 16'h7FFF, 32'hC0008000);
    run_mult("0x1234",     16'h0000, 16'h1234, 32'h00000000);
    run_mult("maxxmax",    16'h7FFF, 16'h7FFF, 32'h3FFF0001);
    run_mult("1234xm2",    16'h1234, 16'hFFFE, 32'hFFFFDB98);
    run_mult("2xmin",      16'h0002, 16'h8000, 32'hFFFF0000);

    // backpressure: result must hold while inputs churn
    out_ready = 1'b0;
    x = 16'h0100;
    y = 16'h0010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bp latency", cyc, 8);
    held = product;
    check("bp product", held, 32'h00001000);
    pv_bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      x = 16'h1111 * i[15:0];
      y = 16'h2222 + i[15:0];
      tick();
      if (!out_valid || product !== held || in_ready) pv_bad = 1;
    end
    check("bp hold stable", pv_bad, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp release", {out_valid, in_ready, busy, product}, {3'b010, 32'h00001000});

    // back-to-back with in_valid and out_ready held high
    idx = 0;
    oidx = 0;
    x = bx[0];
    y = by[0];
    in_valid = 1'b1;
    for (cyc = 0; cyc < 80 && oidx < 4; cyc++) begin
      acc_now = in_ready && in_valid;
      tick();
      if (acc_now) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 4) begin
          x = bx[idx];
          y = by[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check($sformatf("b2b product %0d", oidx), product, bp[oidx]);
        oidx++;
      end
    end
    in_valid = 1'b0;
    check("b2b accepts", idx, 4);
    check("b2b results", oidx, 4);
    for (int i = 1; i < 4; i++)
      check($sformatf("b2b gap %0d", i), acc_cyc[i] - acc_cyc[i-1], 10);
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end

    // reset at step 3 aborts the multiply
    x = 16'h1234;
    y = 16'h5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort outputs", {out_valid, product, in_ready, busy}, {1'b0, 32'h0, 1'b1, 1'b0});
    run_mult("7xm9", 16'h0007, 16'hFFF7, 32'hFFFFFFC1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
